dmem_block_responder: RTL and testbench
=======================================

// Module: dmem_block_responder
// PURPOSE
// Memory-side responder for data-cache block traffic: accepts one block-refill
// (read) or dirty-block writeback (write) request at a time from the data cache,
// models a fixed access latency, then commits the write or returns the block.
// Sits between data_cache and the block-organised data store. Owns the storage array.
// PARAMETERS
// WORD_SIZE   32    bits per word
// BLOCK_SIZE  16    words per block; one block = WORD_SIZE*BLOCK_SIZE bits
// INDEX_BITS  10    log2 of blocks held; depth = 2**INDEX_BITS
// LATENCY     4     cycles spent in WAIT per request; legal range 1..255
// PORTS
// clk         in   1                     single clock, all state on posedge
// rst_n       in   1                     asynchronous, active-low reset
// req_valid   in   1                     request present
// req_ready   out  1                     responder can accept a request
// req_write   in   1                     1 = writeback block, 0 = refill read
// req_addr    in   WORD_SIZE             byte/word pointer; block index = req_addr[INDEX_BITS+3:4]
// req_block   in   WORD_SIZE*BLOCK_SIZE  writeback data, ignored on read
// resp_valid  out  1                     response present
// resp_ready  in   1                     cache accepts response
// resp_write  out  1                     echo of req_write for this response
// resp_block  out  WORD_SIZE*BLOCK_SIZE  refill data; holds last read data on write responses
// busy        out  1                     1 in WAIT or RESP
// BEHAVIOUR
// - Reset (rst_n low, async): state=IDLE, req_ready=1, resp_valid=0, resp_write=0,
//   resp_block=0, busy=0, latency counter=0. Storage array NOT cleared by reset.
// - FSM IDLE -> WAIT -> RESP -> IDLE.
// - IDLE: req_ready=1. On edge with req_valid&&req_ready: latch write flag,
//   block index, req_block; counter <= LATENCY-1; go WAIT.
// - WAIT: req_ready=0; counter decrements each edge. On edge with counter==0:
//   write -> mem[idx] <= latched block; read -> resp_block <= mem[idx]; go RESP.
//   resp_valid therefore rises exactly LATENCY edges after the accept edge.
// - RESP: resp_valid=1, resp_write/resp_block stable until handshake.
//   On edge with resp_valid&&resp_ready go IDLE; resp_valid=0 next cycle.
//   Back-to-back: new request accepted no earlier than the cycle after IDLE re-entry.
// - Address: offset bits [3:0] ignored; tag bits above INDEX_BITS+3 ignored
//   (aliasing wraps modulo depth).
// - Read-after-write same index: read returns the written block (commit precedes).
// - Write commits whole block; no partial/word-masked writes.
// - req_* changes while not in IDLE are ignored (latched copy used).
// - Reset mid-WAIT: request dropped; a write whose commit edge had not occurred is
//   NOT written. Reset during RESP drops the response; array unaffected.
// - resp_ready held high in IDLE/WAIT has no effect.
// TESTING
// 1 Reset: rst_n=0 mid-cycle -> req_ready=1, resp_valid=0, resp_block=0 immediately.
// 2 Write addr 0x00000130 block {16{32'hA5A5_0001}}, LATENCY=4 -> resp_valid at
//   accept+4 edges, resp_write=1; then read addr 0x0000013C -> same block returned.
// 3 Aliasing: write 0x00004130 with B1, read 0x00000130 -> returns B1.
// 4 Backpressure: read with resp_ready=0 for 10 cycles -> resp_valid, resp_block stable,
//   req_ready=0, second req_valid not accepted; resp_ready=1 -> IDLE next edge.
// 5 Reset mid-WAIT: write 32'hDEAD_BEEF-filled block to index 5, rst_n low at accept+2
//   -> later read of index 5 returns prior contents.
// 6 LATENCY=1 build: back-to-back read/write/read on index 7 -> latencies of 1 edge each,
//   final read returns the written block.

Source files
------------

// File: rtl/dmem_block_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_block_responder_if
// Brief    : Request/response bundle between the data cache (master) and the
//            block-organised memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_block_responder_if #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 16
);
  // Request channel
  logic                             req_valid;
  logic                             req_ready;
  logic                             req_write;
  logic [WORD_SIZE-1:0]             req_addr;
  logic [WORD_SIZE*BLOCK_SIZE-1:0]  req_block;
  // Response channel
  logic                             resp_valid;
  logic                             resp_ready;
  logic                             resp_write;
  logic [WORD_SIZE*BLOCK_SIZE-1:0]  resp_block;
  // Status
  logic                             busy;

  // Data cache side
  modport master (
    output req_valid, req_write, req_addr, req_block, resp_ready,
    input  req_ready, resp_valid, resp_write, resp_block, busy
  );

  // Memory responder side
  modport slave (
    input  req_valid, req_write, req_addr, req_block, resp_ready,
    output req_ready, resp_valid, resp_write, resp_block, busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_block_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_block_responder
// Brief    : Memory-side responder for data-cache block traffic. Accepts one
//            block refill (read) or dirty-block writeback (write) at a time,
//            spends a fixed latency in WAIT, then commits the write or returns
//            the block. Owns the block storage array.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_block_responder #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 16,
  parameter int INDEX_BITS = 10,
  parameter int LATENCY    = 4    // legal range 1..255
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  dmem_block_responder_if.slave   bus
);

  localparam int              c_BLOCK_W  = WORD_SIZE * BLOCK_SIZE;
  localparam int              c_DEPTH    = 1 << INDEX_BITS;
  // Counter preload: the commit edge is the one on which the counter is zero,
  // so loading LATENCY-1 puts resp_valid exactly LATENCY edges after accept.
  localparam logic [7:0]      c_LAT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next;

  logic [7:0]                 r_cnt;
  logic                       r_write;
  logic [INDEX_BITS-1:0]      r_idx;
  logic [c_BLOCK_W-1:0]       r_wblock;
  logic                       r_resp_write;
  logic [c_BLOCK_W-1:0]       r_resp_block;

  // Storage array; deliberately not cleared by reset.
  logic [c_BLOCK_W-1:0]       r_mem [c_DEPTH];

  logic                       w_accept;
  logic                       w_commit;
  logic                       w_resp_done;
  logic [INDEX_BITS-1:0]      w_req_idx;
  logic                       w_unused_addr;

  // Only the block index field of the address matters: byte/word offset bits
  // are dropped and tag bits above the index alias modulo the depth.
  assign w_req_idx     = bus.req_addr[INDEX_BITS+3:4];
  assign w_unused_addr = ^bus.req_addr;

  assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
  assign w_commit    = (r_state == S_WAIT) && (r_cnt == 8'd0);
  assign w_resp_done = (r_state == S_RESP) && bus.resp_ready;

  // State register; reset drops any request or response in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: IDLE -> WAIT on accept, WAIT -> RESP on commit, RESP -> IDLE on handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)    w_next = S_WAIT;
      S_WAIT: if (w_commit)    w_next = S_RESP;
      S_RESP: if (w_resp_done) w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  // Latency counter: preloaded on accept, counts down while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'd0;
    end else if (w_accept) begin
      r_cnt <= c_LAT_LOAD;
    end else if ((r_state == S_WAIT) && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  // Request control capture; later changes on req_* are ignored until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_write <= bus.req_write;
      r_idx   <= w_req_idx;
    end
  end

  // Writeback data capture; a wide holding register that needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wblock <= bus.req_block;
    end
  end

  // Array commit; gated by the reset-cleared state so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (w_commit && r_write) begin
      r_mem[r_idx] <= r_wblock;
    end
  end

  // Response registers: write flag echoed on every commit, data only on reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_write <= 1'b0;
      r_resp_block <= '0;
    end else if (w_commit) begin
      r_resp_write <= r_write;
      if (!r_write) begin
        r_resp_block <= r_mem[r_idx];
      end
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.resp_write = r_resp_write;
  assign bus.resp_block = r_resp_block;

endmodule
`default_nettype wire

// File: tb/tb_dmem_block_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_block_responder
// Brief    : Self-checking bench for dmem_block_responder. A LATENCY=4 build
//            runs a vector table plus backpressure and reset-abort sequences;
//            a LATENCY=1 build runs a back-to-back read/write/read sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_block_responder;

  typedef logic [511:0] blk_t;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    blk_t        wblk;
    blk_t        exp_blk;
  } vec_t;

  logic clk;
  logic rst_n;
  logic sel;          // 0 = LATENCY 4 build, 1 = LATENCY 1 build

  int n_tests;
  int n_fail;

  // Bench-side drive values, routed to the selected build
  logic        t_req_valid;
  logic        t_req_write;
  logic [31:0] t_req_addr;
  blk_t        t_req_block;
  logic        t_resp_ready;

  // Outputs of the selected build
  logic        m_req_ready;
  logic        m_resp_valid;
  logic        m_resp_write;
  blk_t        m_resp_block;
  logic        m_busy;

  dmem_block_responder_if #(.WORD_SIZE(32), .BLOCK_SIZE(16)) b4 ();
  dmem_block_responder_if #(.WORD_SIZE(32), .BLOCK_SIZE(16)) b1 ();

  dmem_block_responder #(
    .WORD_SIZE(32), .BLOCK_SIZE(16), .INDEX_BITS(10), .LATENCY(4)
  ) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  dmem_block_responder #(
    .WORD_SIZE(32), .BLOCK_SIZE(16), .INDEX_BITS(10), .LATENCY(1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  assign b4.req_valid  = (sel == 1'b0) ? t_req_valid  : 1'b0;
  assign b4.req_write  = t_req_write;
  assign b4.req_addr   = t_req_addr;
  assign b4.req_block  = t_req_block;
  assign b4.resp_ready = (sel == 1'b0) ? t_resp_ready : 1'b0;

  assign b1.req_valid  = (sel == 1'b1) ? t_req_valid  : 1'b0;
  assign b1.req_write  = t_req_write;
  assign b1.req_addr   = t_req_addr;
  assign b1.req_block  = t_req_block;
  assign b1.resp_ready = (sel == 1'b1) ? t_resp_ready : 1'b0;

  assign m_req_ready  = sel ? b1.req_ready  : b4.req_ready;
  assign m_resp_valid = sel ? b1.resp_valid : b4.resp_valid;
  assign m_resp_write = sel ? b1.resp_write : b4.resp_write;
  assign m_resp_block = sel ? b1.resp_block : b4.resp_block;
  assign m_busy       = sel ? b1.busy       : b4.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic blk_t rep(input logic [31:0] w);
    blk_t b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = w;
    return b;
  endfunction

  // Distinct word per lane so word-order faults show up
  function automatic blk_t mk(input logic [31:0] base);
    blk_t b;
    for (int i = 0; i < 16; i++) b[i*32 +: 32] = base + 32'(i);
    return b;
  endfunction

  task automatic check(input string nm, input blk_t act, input blk_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction from IDLE (#1 after an edge). req_valid stays high with
  // scrambled fields during WAIT to show the latched copy is used.
  task automatic run_txn(input string nm, input logic wr, input logic [31:0] addr,
                         input blk_t blk, input int exp_lat, input bit chk_blk,
                         input blk_t exp_blk);
    int lat;
    bit seen;
    t_req_valid  = 1'b1;
    t_req_write  = wr;
    t_req_addr   = addr;
    t_req_block  = blk;
    t_resp_ready = 1'b1;
    @(posedge clk); #1;
    t_req_write = ~wr;
    t_req_addr  = addr ^ 32'h0000_0150;
    t_req_block = ~blk;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (m_resp_valid) seen = 1'b1;
    end
    t_req_valid = 1'b0;
    check({nm, "_lat"}, 512'(lat), 512'(exp_lat));
    check({nm, "_rw"}, 512'(m_resp_write), 512'(wr));
    if (chk_blk) check({nm, "_blk"}, m_resp_block, exp_blk);
    @(posedge clk); #1;
    check({nm, "_idle"}, 512'({m_req_ready, m_resp_valid, m_busy}), 512'(3'b100));
  endtask

  vec_t vecs[9];
  blk_t b_a5;
  blk_t b_1;

  initial begin
    int lat;
    n_tests      = 0;
    n_fail       = 0;
    sel          = 1'b0;
    rst_n        = 1'b1;
    t_req_valid  = 1'b0;
    t_req_write  = 1'b0;
    t_req_addr   = '0;
    t_req_block  = '0;
    t_resp_ready = 1'b0;

    b_a5 = rep(32'hA5A5_0001);
    b_1  = mk(32'h1111_0000);

    // Write responses carry the data of the most recent read (0 after reset)
    vecs[0] = '{"v0_wr130",  1'b1, 32'h0000_0130, b_a5,              '0};
    vecs[1] = '{"v1_rd13c",  1'b0, 32'h0000_013C, '0,                b_a5};
    vecs[2] = '{"v2_wr4130", 1'b1, 32'h0000_4130, b_1,               b_a5};
    vecs[3] = '{"v3_rd130",  1'b0, 32'h0000_0130, '0,                b_1};
    vecs[4] = '{"v4_wr50",   1'b1, 32'h0000_0050, mk(32'h5555_0000), b_1};
    vecs[5] = '{"v5_rd5f",   1'b0, 32'h0000_005F, '0,                mk(32'h5555_0000)};
    vecs[6] = '{"v6_wr3ff",  1'b1, 32'h0000_3FF0, mk(32'h3FF0_0000), mk(32'h5555_0000)};
    vecs[7] = '{"v7_rdtop",  1'b0, 32'hFFFF_FFF0, '0,                mk(32'h3FF0_0000)};
    vecs[8] = '{"v8_rd10135",1'b0, 32'h0001_0135, '0,                b_1};

    // Asynchronous reset asserted mid-cycle takes effect without a clock edge
    #12;
    rst_n = 1'b0;
    #1;
    check("rst4_flags", 512'({m_req_ready, m_resp_valid, m_busy, m_resp_write}), 512'(4'b1000));
    check("rst4_blk", m_resp_block, '0);
    sel = 1'b1;
    #1;
    check("rst1_flags", 512'({m_req_ready, m_resp_valid, m_busy, m_resp_write}), 512'(4'b1000));
    check("rst1_blk", m_resp_block, '0);
    sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table on the LATENCY 4 build
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].name, vecs[i].wr, vecs[i].addr, vecs[i].wblk, 4, 1'b1, vecs[i].exp_blk);
    end

    // Backpressure: response held for 10 cycles, competing request refused
    t_resp_ready = 1'b0;
    t_req_valid  = 1'b1;
    t_req_write  = 1'b0;
    t_req_addr   = 32'h0000_0130;
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    lat = 0;
    while (!m_resp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 512'(lat), 512'(4));
    t_req_valid = 1'b1;
    t_req_write = 1'b1;
    t_req_addr  = 32'h0000_0130;
    t_req_block = rep(32'hBAD0_BAD0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_flags", 512'({m_resp_valid, m_req_ready, m_busy, m_resp_write}), 512'(4'b1010));
      check("bp_hold_blk", m_resp_block, b_1);
    end
    t_req_valid  = 1'b0;
    t_resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 512'({m_resp_valid, m_req_ready, m_busy}), 512'(3'b010));
    // The refused write must not have reached the array
    run_txn("bp_after", 1'b0, 32'h0000_0130, '0, 4, 1'b1, b_1);

    // Reset two edges after accepting a write: the write is lost
    t_req_valid = 1'b1;
    t_req_write = 1'b1;
    t_req_addr  = 32'h0000_0050;
    t_req_block = rep(32'hDEAD_BEEF);
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rw_busy", 512'(m_busy), 512'(1'b1));
    rst_n = 1'b0;
    #1;
    check("rw_rst_flags", 512'({m_req_ready, m_resp_valid, m_busy, m_resp_write}), 512'(4'b1000));
    check("rw_rst_blk", m_resp_block, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn("rw_rd5", 1'b0, 32'h0000_0058, '0, 4, 1'b1, mk(32'h5555_0000));

    // LATENCY 1 build: back-to-back read / write / read on index 7
    sel = 1'b1;
    run_txn("l1_rd7", 1'b0, 32'h0000_0070, '0, 1, 1'b0, '0);
    run_txn("l1_wr7", 1'b1, 32'h0000_0074, mk(32'h7777_0000), 1, 1'b0, '0);
    run_txn("l1_rd7b", 1'b0, 32'h0000_007C, '0, 1, 1'b1, mk(32'h7777_0000));
    run_txn("l1_wr7b", 1'b1, 32'h0000_0078, rep(32'h0), 1, 1'b1, mk(32'h7777_0000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
